// File: rtl/chg_update_sequencer_pkg.sv
// Shared definitions for the admittance-change sequencer: state encoding and the
// change-entry field layout (also used by busWriteY and updateYcomputation).
package chg_update_sequencer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_LATCH,
    ST_COMPUTE,
    ST_WRITE,
    ST_ADVANCE,
    ST_DONE,
    ST_ERR
  } seq_state_e;

  localparam int ENTRY_W  = 80;
  localparam int ROW_MSB  = 79;
  localparam int ROW_LSB  = 64;
  localparam int COL_MSB  = 63;
  localparam int COL_LSB  = 48;
  localparam int REAL_MSB = 47;
  localparam int REAL_LSB = 24;
  localparam int IMG_MSB  = 23;
  localparam int IMG_LSB  = 0;

  localparam int ROW_W  = ROW_MSB - ROW_LSB + 1;
  localparam int COL_W  = COL_MSB - COL_LSB + 1;
  localparam int REAL_W = REAL_MSB - REAL_LSB + 1;
  localparam int IMG_W  = IMG_MSB - IMG_LSB + 1;

  // An entry whose admittance change is exactly zero leaves Y untouched.
  function automatic logic isZeroValue(input logic [ENTRY_W-1:0] entry);
    return (entry[REAL_MSB:REAL_LSB] == '0) && (entry[IMG_MSB:IMG_LSB] == '0);
  endfunction

endpackage

// File: rtl/chg_seq_watchdog.sv
// Timeout counter for the sequencer's compute/write waits; expired_o marks the
// cycle in which the count reaches TIMEOUT.
module chg_seq_watchdog #(
  parameter int TIMEOUT = 1023
) (
  input  logic clock,
  input  logic reset,
  input  logic clear_i,
  input  logic enable_i,
  output logic expired_o
);

  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (enable_i) begin
      count_d = count_q + CW'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  // A done flag arriving in the last cycle (clear) wins over the timeout.
  assign expired_o = enable_i && !clear_i && (count_q == CW'(TIMEOUT - 1));

endmodule

// File: rtl/chg_update_sequencer.sv
// Walks the change list entry by entry, scheduling Y compute then Y write-back.
// Optional build macro CHG_SEQ_SKIP_ZERO_EN: skip entries whose value is zero.
module chg_update_sequencer
  import chg_update_sequencer_pkg::*;
#(
  parameter int ADDR_W  = 11,
  parameter int CNT_W   = 16,
  parameter int TIMEOUT = 1023
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               start,
  input  logic [CNT_W-1:0]   numChanges,
  input  logic [ADDR_W-1:0]  chgBaseAddr,
  output logic [ADDR_W-1:0]  op_chgReadAddr,
  input  logic [ENTRY_W-1:0] in_chgReadData,
  output logic [ROW_W-1:0]   op_chgRow,
  output logic [COL_W-1:0]   op_chgCol,
  output logic [REAL_W-1:0]  op_chgReal,
  output logic [IMG_W-1:0]   op_chgImg,
  output logic               op_computeEnable,
  output logic               op_writeEnable,
  input  logic               in_computeDone,
  input  logic               in_writeDone,
  output logic               op_busy,
  output logic               op_allDone,
  output logic               op_error,
  output logic [CNT_W-1:0]   op_entryIdx
);

  seq_state_e         state_q, state_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [ADDR_W-1:0]  base_q, base_d;
  logic [CNT_W-1:0]   idx_q, idx_d;
  logic [ENTRY_W-1:0] entry_q, entry_d;
  logic               error_q, error_d;
  logic               allDone_q, allDone_d;

  logic wdClear, wdEnable, wdExpired;
  logic lastEntry;

  chg_seq_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .clock     (clock),
    .reset     (reset),
    .clear_i   (wdClear),
    .enable_i  (wdEnable),
    .expired_o (wdExpired)
  );

  assign lastEntry = (idx_q + CNT_W'(1)) == count_q;

  always_comb begin
    state_d          = state_q;
    count_d          = count_q;
    base_d           = base_q;
    idx_d            = idx_q;
    entry_d          = entry_q;
    error_d          = error_q;
    op_computeEnable = 1'b0;
    op_writeEnable   = 1'b0;
    op_busy          = 1'b0;
    wdClear          = 1'b1;
    wdEnable         = 1'b0;

    case (state_q)
      // ERR behaves like IDLE for a new start, which restarts from entry 0.
      ST_IDLE, ST_ERR: begin
        if (start) begin
          count_d = numChanges;
          base_d  = chgBaseAddr;
          idx_d   = '0;
          error_d = 1'b0;
          state_d = (numChanges == '0) ? ST_DONE : ST_FETCH;
        end
      end
      ST_FETCH: begin
        op_busy = 1'b1;
        state_d = ST_LATCH;
      end
      ST_LATCH: begin
        op_busy = 1'b1;
        entry_d = in_chgReadData;
`ifdef CHG_SEQ_SKIP_ZERO_EN
        state_d = isZeroValue(in_chgReadData) ? ST_ADVANCE : ST_COMPUTE;
`else
        state_d = ST_COMPUTE;
`endif
      end
      ST_COMPUTE: begin
        op_busy          = 1'b1;
        op_computeEnable = 1'b1;
        wdClear          = in_computeDone;
        wdEnable         = 1'b1;
        if (in_computeDone) begin
          state_d = ST_WRITE;
        end else if (wdExpired) begin
          error_d = 1'b1;
          state_d = ST_ERR;
        end
      end
      ST_WRITE: begin
        op_busy        = 1'b1;
        op_writeEnable = 1'b1;
        wdClear        = in_writeDone;
        wdEnable       = 1'b1;
        if (in_writeDone) begin
          state_d = ST_ADVANCE;
        end else if (wdExpired) begin
          error_d = 1'b1;
          state_d = ST_ERR;
        end
      end
      // The index stays on the final entry so it still names the last one processed.
      ST_ADVANCE: begin
        op_busy = 1'b1;
        if (lastEntry) begin
          state_d = ST_DONE;
        end else begin
          idx_d   = idx_q + CNT_W'(1);
          state_d = ST_FETCH;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign allDone_d = (state_q == ST_DONE);

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      count_q   <= '0;
      base_q    <= '0;
      idx_q     <= '0;
      entry_q   <= '0;
      error_q   <= 1'b0;
      allDone_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      base_q    <= base_d;
      idx_q     <= idx_d;
      entry_q   <= entry_d;
      error_q   <= error_d;
      allDone_q <= allDone_d;
    end
  end

  // Address wraps modulo 2^ADDR_W; it is only meaningful while in FETCH.
  assign op_chgReadAddr = base_q + ADDR_W'(idx_q);
  assign op_chgRow      = entry_q[ROW_MSB:ROW_LSB];
  assign op_chgCol      = entry_q[COL_MSB:COL_LSB];
  assign op_chgReal     = entry_q[REAL_MSB:REAL_LSB];
  assign op_chgImg      = entry_q[IMG_MSB:IMG_LSB];
  assign op_allDone     = allDone_q;
  assign op_error       = error_q;
  assign op_entryIdx    = idx_q;

endmodule

// File: tb/tb_chg_update_sequencer.sv
// Bench for chg_update_sequencer: a timeline built from the per-entry latency
// rules predicts every control output, address and latched entry cycle by cycle.
module tb_chg_update_sequencer;
  import chg_update_sequencer_pkg::*;

  localparam int ADDR_W  = 11;
  localparam int CNT_W   = 16;
  localparam int TIMEOUT = 1023;
  localparam int DEPTH   = 2048;
  localparam int MAXC    = 2048;
`ifdef CHG_SEQ_SKIP_ZERO_EN
  localparam bit SKIP_ZERO = 1'b1;
`else
  localparam bit SKIP_ZERO = 1'b0;
`endif

  logic               clock;
  logic               reset;
  logic               start;
  logic [CNT_W-1:0]   numChanges;
  logic [ADDR_W-1:0]  chgBaseAddr;
  logic [ADDR_W-1:0]  op_chgReadAddr;
  logic [ENTRY_W-1:0] in_chgReadData;
  logic [ROW_W-1:0]   op_chgRow;
  logic [COL_W-1:0]   op_chgCol;
  logic [REAL_W-1:0]  op_chgReal;
  logic [IMG_W-1:0]   op_chgImg;
  logic               op_computeEnable;
  logic               op_writeEnable;
  logic               in_computeDone;
  logic               in_writeDone;
  logic               op_busy;
  logic               op_allDone;
  logic               op_error;
  logic [CNT_W-1:0]   op_entryIdx;

  chg_update_sequencer #(
    .ADDR_W  (ADDR_W),
    .CNT_W   (CNT_W),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clock            (clock),
    .reset            (reset),
    .start            (start),
    .numChanges       (numChanges),
    .chgBaseAddr      (chgBaseAddr),
    .op_chgReadAddr   (op_chgReadAddr),
    .in_chgReadData   (in_chgReadData),
    .op_chgRow        (op_chgRow),
    .op_chgCol        (op_chgCol),
    .op_chgReal       (op_chgReal),
    .op_chgImg        (op_chgImg),
    .op_computeEnable (op_computeEnable),
    .op_writeEnable   (op_writeEnable),
    .in_computeDone   (in_computeDone),
    .in_writeDone     (in_writeDone),
    .op_busy          (op_busy),
    .op_allDone       (op_allDone),
    .op_error         (op_error),
    .op_entryIdx      (op_entryIdx)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Change SRAM model: synchronous read, data valid one cycle after the address.
  logic [ENTRY_W-1:0] mem [DEPTH];
  always @(posedge clock) in_chgReadData <= mem[op_chgReadAddr];

  int passCount = 0;
  int checkCount = 0;
  bit errSticky = 1'b0;

  // Per-cycle expectations and stimulus schedule for one list run (cycle 0 = start).
  bit               expCe     [MAXC];
  bit               expWe     [MAXC];
  bit               cDoneAt   [MAXC];
  bit               wDoneAt   [MAXC];
  bit               noiseC    [MAXC];
  bit               noiseW    [MAXC];
  bit               noiseStart[MAXC];
  bit               addrChk   [MAXC];
  logic [ADDR_W-1:0] expAddr  [MAXC];
  int               entryAt   [MAXC];

  task automatic checkOutput(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checkCount++;
    if (got === exp) passCount++;
    else $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic logic [111:0] allOutputs();
    return {op_computeEnable, op_writeEnable, op_busy, op_allDone, op_error,
            op_chgReadAddr, op_entryIdx, op_chgRow, op_chgCol, op_chgReal, op_chgImg};
  endfunction

  // Runs one list: hangEntry >= 0 withholds that entry's compute done to force a timeout.
  task automatic applyStimulus(input int n, input int base, input int hangEntry, input bit fixedDelay);
    int t, a, e, dc, dw, len, lastBusy, allDoneAt, errAt, expIdx;
    bit hung, zero, noisy;
    logic [ADDR_W-1:0] ea;
    logic [4:0] expCtl;

    for (int k = 0; k < MAXC; k++) begin
      expCe[k] = 0; expWe[k] = 0; cDoneAt[k] = 0; wDoneAt[k] = 0;
      noiseC[k] = 0; noiseW[k] = 0; noiseStart[k] = 0; addrChk[k] = 0;
      expAddr[k] = '0; entryAt[k] = -1;
    end
    noisy = !fixedDelay && (hangEntry < 0);
    hung = 0; errAt = MAXC; allDoneAt = -1; lastBusy = 0; a = 0; len = 4;

    if (n == 0) begin
      allDoneAt = 2;
    end else begin
      t = 3;
      for (int i = 0; i < n; i++) begin
        ea = ADDR_W'((base + i) % DEPTH);
        addrChk[t-2] = 1; expAddr[t-2] = ea; entryAt[t] = i;
        zero = (mem[ea][REAL_MSB:REAL_LSB] == '0) && (mem[ea][IMG_MSB:IMG_LSB] == '0);
        if (SKIP_ZERO && zero) begin
          a = t;
        end else if (i == hangEntry) begin
          for (int k = t; k < t + TIMEOUT; k++) expCe[k] = 1;
          errAt = t + TIMEOUT;
          hung = 1;
          break;
        end else begin
          dc = fixedDelay ? 5 : int'($urandom_range(0, 6));
          dw = fixedDelay ? 5 : int'($urandom_range(0, 6));
          for (int k = t; k <= t + dc; k++) begin
            expCe[k] = 1;
            noiseW[k] = noisy && ($urandom_range(0, 2) == 0);
          end
          cDoneAt[t+dc] = 1;
          e = t + dc + 1 + dw;
          for (int k = t + dc + 1; k <= e; k++) begin
            expWe[k] = 1;
            noiseC[k] = noisy && ($urandom_range(0, 2) == 0);
          end
          wDoneAt[e] = 1; entryAt[e] = i;
          a = e + 1;
        end
        t = a + 3;
      end
      if (hung) begin
        lastBusy = errAt - 1; len = errAt + 4;
      end else begin
        lastBusy = a; allDoneAt = a + 2; len = a + 4;
      end
    end
    for (int k = 1; k <= lastBusy; k++) noiseStart[k] = noisy && ($urandom_range(0, 7) == 0);

    for (int k = 0; k < len; k++) begin
      start          = (k == 0) || noiseStart[k];
      numChanges     = (k == 0) ? CNT_W'(n) : CNT_W'($urandom);
      chgBaseAddr    = (k == 0) ? ADDR_W'(base) : ADDR_W'($urandom);
      in_computeDone = cDoneAt[k] | noiseC[k];
      in_writeDone   = wDoneAt[k] | noiseW[k];
      @(negedge clock);
      expCtl = {expCe[k], expWe[k], (k >= 1 && k <= lastBusy), (k == allDoneAt),
                (k == 0) ? errSticky : (k >= errAt)};
      checkOutput($sformatf("ctl@%0d", k),
                  128'({op_computeEnable, op_writeEnable, op_busy, op_allDone, op_error}),
                  128'(expCtl));
      if (addrChk[k]) checkOutput($sformatf("addr@%0d", k), 128'(op_chgReadAddr), 128'(expAddr[k]));
      if (entryAt[k] >= 0) begin
        ea = ADDR_W'((base + entryAt[k]) % DEPTH);
        checkOutput($sformatf("entry@%0d", k),
                    128'({op_chgRow, op_chgCol, op_chgReal, op_chgImg}), 128'(mem[ea]));
        checkOutput($sformatf("idx@%0d", k), 128'(op_entryIdx), 128'(entryAt[k]));
      end
      @(posedge clock); #1;
    end
    start = 0; in_computeDone = 0; in_writeDone = 0;
    expIdx = hung ? hangEntry : ((n > 0) ? n - 1 : 0);
    checkOutput("idxFinal", 128'(op_entryIdx), 128'(expIdx));
    errSticky = hung;
  endtask

  initial begin
    reset = 1; start = 0; numChanges = '0; chgBaseAddr = '0;
    in_computeDone = 0; in_writeDone = 0;
    for (int i = 0; i < DEPTH; i++) begin
      mem[i] = 80'({$urandom, $urandom, $urandom});
      mem[i][REAL_LSB] = 1'b1;
    end
    mem[12'h200] = {16'd1, 16'd2, 24'd0, 24'd0};

    repeat (2) @(posedge clock);
    @(negedge clock);
    checkOutput("resetState", 128'(allOutputs()), 128'(0));
    @(posedge clock); #1;
    reset = 0;
    $display("[TB] reset released");

    applyStimulus(3, 'h010, -1, 1'b1);
    applyStimulus(0, 'h155, -1, 1'b0);
    applyStimulus(2, 'h7FF, -1, 1'b0);
    applyStimulus(2, 'h200, -1, 1'b0);
    for (int r = 0; r < 6; r++)
      applyStimulus(int'($urandom_range(1, 5)), int'($urandom_range(0, DEPTH - 1)), -1, 1'b0);

    $display("[TB] timeout scenario");
    applyStimulus(1, 'h040, 0, 1'b1);
    applyStimulus(3, 'h3F0, -1, 1'b0);

    // Reset while the write phase of entry 0 is open.
    for (int k = 0; k < 7; k++) begin
      start = (k == 0); numChanges = 2; chgBaseAddr = 'h100;
      in_computeDone = (k == 4); reset = (k == 6);
      @(negedge clock);
      if (k == 5) checkOutput("weBeforeRst", 128'(op_writeEnable), 128'(1));
      @(posedge clock); #1;
    end
    reset = 0; start = 0; in_computeDone = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clock);
      checkOutput($sformatf("postRst@%0d", k), 128'(allOutputs()), 128'(0));
      @(posedge clock); #1;
    end
    errSticky = 0;
    applyStimulus(2, 'h123, -1, 1'b0);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
